keyexpand_inv_seq: RTL and testbench

Sequential decryption key scheduler for the AES-128 datapath. It accepts the 128-bit cipher key and runs the forward schedule internally for 10 cycles to reach the round-10 key. It then streams round keys 10 down to 0 over a valid/ready interface, applying the inverse key-expansion step once per accepted key. It feeds the inverse-cipher round engine, which consumes round keys in reverse order.

---
 rtl/keyexpand_inv_seq.sv | 207 ++++++++++++++++++++
 tb/tb_keyexpand_inv_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyexpand_inv_seq.sv
// Purpose: AES-128 decryption key scheduler. It runs the forward schedule up to round 10, then streams round keys 10..0.
// Latency: busy goes high one edge after start. rk_valid rises 11 edges after start. One key per cycle after that.
// Backpressure: rk_valid/rk_ready. While stalled, rk_out and rk_idx hold. No output depends combinationally on any input.
module keyexpand_inv_seq #(
  // The S-box is computed in logic (GF(2^8) inverse followed by the affine map),
  // so no table file has to be present at elaboration. The name is accepted for
  // drop-in compatibility with flows that preload a ROM.
  parameter string SBOX_FILE = "SBOX.hex"
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } state_t;

  if (SBOX_FILE == "") begin : g_sbox_file_unnamed
  end

  state_t           state;
  state_t           state_nxt;
  logic [127:0]     key_r;
  logic [3:0]       cnt;
  logic             done_r;
  logic             hs;

  logic [15:0][7:0] kb;      // key_r viewed as bytes, byte b at [8b+7:8b]
  logic [15:4][7:0] dif;     // upper 12 bytes of the previous round key (inverse step)
  logic [3:0][7:0]  sb_in;   // shared S-box lookup bytes
  logic [3:0][7:0]  sb_out;
  logic [7:0]       rc;
  logic [15:0][7:0] fwd_b;   // F(key_r, cnt)
  logic [15:0][7:0] inv_b;   // G(key_r, cnt-1)

  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Forward S-box: x^254 (multiplicative inverse, 0 maps to 0), then affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, iv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    iv   = gmul(x252, x2);
    return iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
              ^ {iv[3:0], iv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h1b;
      4'd9:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign kb = key_r;
  assign hs = (state == EMIT) && rk_ready;

  // Previous-round upper bytes: each depends only on the current key
  always_comb begin
    dif = '0;
    for (int i = 4; i < 16; i++) dif[i] = kb[i] ^ kb[i-4];
  end

  // Lookup-byte mux: FWD rotates the last word of key_r, EMIT rotates the recovered last word
  always_comb begin
    sb_in = '0;
    if (state == EMIT) begin
      sb_in[0] = dif[13];
      sb_in[1] = dif[14];
      sb_in[2] = dif[15];
      sb_in[3] = dif[12];
    end else begin
      sb_in[0] = kb[13];
      sb_in[1] = kb[14];
      sb_in[2] = kb[15];
      sb_in[3] = kb[12];
    end
  end

  // Four shared S-box lookups
  always_comb begin
    sb_out = '0;
    for (int j = 0; j < 4; j++) sb_out[j] = sbox(sb_in[j]);
  end

  // Round constant for round cnt (forward) or cnt-1 (inverse)
  always_comb begin
    rc = rcon((state == EMIT) ? (cnt - 4'd1) : cnt);
  end

  // Forward and inverse step results
  always_comb begin
    fwd_b    = '0;
    inv_b    = '0;
    fwd_b[0] = sb_out[0] ^ kb[0] ^ rc;
    fwd_b[1] = sb_out[1] ^ kb[1];
    fwd_b[2] = sb_out[2] ^ kb[2];
    fwd_b[3] = sb_out[3] ^ kb[3];
    for (int i = 4; i < 16; i++) fwd_b[i] = kb[i] ^ fwd_b[i-4];
    inv_b[0] = kb[0] ^ sb_out[0] ^ rc;
    inv_b[1] = kb[1] ^ sb_out[1];
    inv_b[2] = kb[2] ^ sb_out[2];
    inv_b[3] = kb[3] ^ sb_out[3];
    for (int i = 4; i < 16; i++) inv_b[i] = dif[i];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FWD;
      FWD:     if (cnt == 4'd9) state_nxt = EMIT;
      EMIT:    if (hs && (cnt == 4'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Key register, round counter and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r  <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_r <= key_in;
            cnt   <= 4'd0;
          end
        end
        FWD: begin
          key_r <= fwd_b;
          cnt   <= cnt + 4'd1;   // reaches 10 on the last forward step
        end
        EMIT: begin
          if (hs) begin
            if (cnt != 4'd0) begin
              key_r <= inv_b;
              cnt   <= cnt - 4'd1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    busy     = (state != IDLE);
    rk_valid = (state == EMIT);
    rk_out   = key_r;
    rk_idx   = cnt;
    done     = done_r;
  end

endmodule

// File: tb/tb_keyexpand_inv_seq.sv
// Bench for keyexpand_inv_seq. It checks FIPS-197 vectors from a table, then hand-written stall, reset and start-hold sequences.
// After that it runs 1000 random keys against a word-level key-expansion model (reference S-box built by the generator-3 walk).
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled at the same point.
module tb_keyexpand_inv_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbm [0:255];
  logic [127:0] mrk [0:10];
  logic [127:0] got [0:10];

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [0:4];

  localparam logic [127:0] FIPS_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;

  keyexpand_inv_seq #(.SBOX_FILE("SBOX.hex")) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference S-box: walk the multiplicative group with generator 3 and its inverse
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbm[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbm[0] = 8'h63;
  endtask

  // Word-level FIPS-197 key expansion into mrk[0..10]
  task automatic expand(input logic [127:0] key);
    logic [7:0] wb [0:43][0:3];
    logic [7:0] t [0:3];
    logic [7:0] rcv;
    rcv = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) wb[i][j] = key[8*(4*i+j) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = wb[i-1][j];
      if (i % 4 == 0) begin
        t[0] = sbm[wb[i-1][1]] ^ rcv;
        t[1] = sbm[wb[i-1][2]];
        t[2] = sbm[wb[i-1][3]];
        t[3] = sbm[wb[i-1][0]];
        rcv  = rcv[7] ? ({rcv[6:0], 1'b0} ^ 8'h1b) : {rcv[6:0], 1'b0};
      end
      for (int j = 0; j < 4; j++) wb[i][j] = wb[i-4][j] ^ t[j];
    end
    for (int r = 0; r < 11; r++)
      for (int w = 0; w < 4; w++)
        for (int j = 0; j < 4; j++) mrk[r][8*(4*w+j) +: 8] = wb[4*r+w][j];
  endtask

  task automatic drive_poke(input int poke);
    if (poke == 1) begin
      start  = ($urandom_range(0, 1) == 1);
      key_in = {$urandom, $urandom, $urandom, $urandom};
    end else if (poke == 2) begin
      start = 1'b1;
    end
  endtask

  // Called in the cycle after the accepting start edge; returns in the done cycle.
  // mode 0: ready held high, 1: random ready, 2: random plus 5-cycle stalls at idx 10 and 0.
  // poke 0: start low, 1: random start/key noise, 2: start held high.
  task automatic run_keys(input logic [127:0] key, input int mode, input int poke);
    int lat, idx, nhs, at_idx, ecyc;
    bit r;
    bit busy_ok;
    expand(key);
    lat     = 0;
    busy_ok = 1'b1;
    while (!rk_valid && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      drive_poke(poke);
      rk_ready = ($urandom_range(0, 1) == 1);
      tick();
      lat++;
    end
    check_int("first_valid_latency", lat, 10);
    check_int("busy_during_fwd", int'(busy_ok), 1);
    if (!rk_valid) begin
      if (poke != 2) start = 1'b0;
      return;
    end
    idx    = 10;
    nhs    = 0;
    at_idx = 0;
    ecyc   = 0;
    while (idx >= 0 && ecyc < 300) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = ((idx == 10 || idx == 0) && at_idx < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
      endcase
      rk_ready = r;
      drive_poke(poke);
      check_vec("emit_key", {rk_valid, done, rk_idx, rk_out}, {1'b1, 1'b0, idx[3:0], mrk[idx]});
      if (r) begin
        got[idx] = rk_out;
        idx--;
        nhs++;
        at_idx = 0;
      end else begin
        at_idx++;
      end
      tick();
      ecyc++;
    end
    if (poke != 2) start = 1'b0;
    rk_ready = 1'b0;
    check_int("handshakes", nhs, 11);
    if (mode == 0) check_int("emit_cycles", ecyc, 11);
    check_vec("done_cycle", {131'd0, done, busy, rk_valid}, {131'd0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    logic [127:0] cur, nxt, k6;
    int n;
    bit chain;

    tbl[0] = '{FIPS_KEY, 10, 128'ha60c63b6c80c3fe18925eec9a8f914d0};
    tbl[1] = '{FIPS_KEY, 1,  128'h05766c2a3939a323b12c548817fefaa0};
    tbl[2] = '{FIPS_KEY, 0,  FIPS_KEY};
    tbl[3] = '{128'd0,   10, 128'h8e188f6fcf51e92311e2923ecb5befb4};
    tbl[4] = '{128'd0,   0,  128'd0};

    build_sbox();
    rst_n    = 1'b0;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    tick();
    tick();
    check_vec("reset_values", {busy, rk_valid, done, rk_idx, rk_out}, 134'd0);
    #2 rst_n = 1'b1;
    tick();

    // Table vectors, ready held high
    for (int v = 0; v < 5; v++) begin
      start  = 1'b1;
      key_in = tbl[v].key;
      tick();
      start = 1'b0;
      run_keys(tbl[v].key, 0, 0);
      check_vec("table_key", {6'd0, got[tbl[v].idx]}, {6'd0, tbl[v].exp});
      tick();
      check_vec("after_done", {131'd0, done, busy, rk_valid}, 134'd0);
    end

    // Backpressure with long stalls at idx 10 and 0, plus ignored start pulses
    start  = 1'b1;
    key_in = FIPS_KEY;
    tick();
    run_keys(FIPS_KEY, 2, 1);
    tick();
    check_vec("bp_after_done", {131'd0, done, busy, rk_valid}, 134'd0);

    // start held high: restarts only from IDLE, right in the done cycle
    cur    = {$urandom, $urandom, $urandom, $urandom};
    start  = 1'b1;
    key_in = cur;
    tick();
    run_keys(cur, 1, 2);
    tick();
    check_vec("hold_restart", {131'd0, done, busy, rk_valid}, {131'd0, 1'b0, 1'b1, 1'b0});
    run_keys(cur, 0, 2);
    start = 1'b0;
    tick();
    check_vec("hold_released", {131'd0, done, busy, rk_valid}, 134'd0);

    // Reset mid-stall at idx 6, then a zero-key schedule
    expand(FIPS_KEY);
    k6       = mrk[6];
    rk_ready = 1'b1;
    start    = 1'b1;
    key_in   = FIPS_KEY;
    tick();
    start = 1'b0;
    n     = 0;
    while (!(rk_valid && rk_idx == 4'd6) && n < 100) begin
      tick();
      n++;
    end
    rk_ready = 1'b0;
    tick();
    tick();
    check_vec("stall_idx6", {rk_valid, done, rk_idx, rk_out}, {1'b1, 1'b0, 4'd6, k6});
    #3 rst_n = 1'b0;
    #1 check_vec("reset_mid_stall", {busy, rk_valid, done, rk_idx, rk_out}, 134'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check_vec("after_reset", {busy, rk_valid, done, rk_idx, rk_out}, 134'd0);
    start  = 1'b1;
    key_in = '0;
    tick();
    start = 1'b0;
    run_keys(128'd0, 0, 0);
    check_vec("zero_key_r10", {6'd0, got[10]}, {6'd0, 128'h8e188f6fcf51e92311e2923ecb5befb4});
    tick();

    // Random keys, random flow control, optional back-to-back start in the done cycle
    cur    = {$urandom, $urandom, $urandom, $urandom};
    start  = 1'b1;
    key_in = cur;
    tick();
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      run_keys(cur, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
      if (i == 999) begin
        tick();
      end else begin
        chain = ($urandom_range(0, 1) == 1);
        nxt   = {$urandom, $urandom, $urandom, $urandom};
        if (!chain) begin
          tick();
          check_vec("rand_idle", {131'd0, done, busy, rk_valid}, 134'd0);
        end
        start  = 1'b1;
        key_in = nxt;
        tick();
        start = 1'b0;
        check_vec("rand_started", {131'd0, done, busy, rk_valid}, {131'd0, 1'b0, 1'b1, 1'b0});
        cur = nxt;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
